// File: rtl/box_avg_prefilter_if.sv
// box_avg_prefilter_if: source/destination memory ports and start/busy/done control of the pre-filter
interface box_avg_prefilter_if #(parameter int BPP = 3);
  logic start, busy, done, wr_en;
  logic [8*BPP-1:0] pixel_in, pixel_out;
  logic [9:0] rd_adrr, wr_adrr;
  modport master(input start, pixel_in, output busy, done, wr_en, pixel_out, rd_adrr, wr_adrr);
  modport slave(output start, pixel_in, input busy, done, wr_en, pixel_out, rd_adrr, wr_adrr);
endinterface

// File: rtl/box_avg_prefilter.sv
// box_avg_prefilter: memory-to-memory rounded 2x2 box average with edge clamp, one pixel per 5 cycles
module box_avg_prefilter #(
  parameter int BPP = 3,
  parameter int HIEGHT = 30,
  parameter int WIDTH = 30
) (
  input logic clk,
  input logic rst,
  box_avg_prefilter_if.master bus
);
  localparam int RW = HIEGHT > 1 ? $clog2(HIEGHT) : 1;
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, WR} state_t;
  state_t state, state_nx;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [9:0] base, addr_b, addr_c, addr_d;
  logic [BPP-1:0][9:0] acc, acc_nx, rnd;
  logic last_r, last_c, last;
  assign last_r = row == RW'(HIEGHT - 1);
  assign last_c = col == CW'(WIDTH - 1);
  assign last = last_r && last_c;
  // base tracks row*WIDTH+col; neighbours are offsets that collapse to zero at the clamped edges
  assign addr_b = base + 10'(!last_c);
  assign addr_c = last_r ? base : base + 10'(WIDTH);
  assign addr_d = addr_c + 10'(!last_c);
  always_comb begin
    acc_nx = '0;
    rnd = '0;
    for (int k = 0; k < BPP; k++) begin
      acc_nx[k] = (state == P0 ? 10'd0 : acc[k]) + {2'b00, bus.pixel_in[8*k +: 8]};
      rnd[k] = acc[k] + 10'd2;
    end
  end
  always_comb begin
    state_nx = IDLE;
    case (state)
      IDLE: state_nx = bus.start ? P0 : IDLE;
      P0: state_nx = P1;
      P1: state_nx = P2;
      P2: state_nx = P3;
      P3: state_nx = WR;
      WR: state_nx = last ? IDLE : P0;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      row <= '0;
      col <= '0;
      base <= '0;
      acc <= '0;
      bus.rd_adrr <= '0;
      bus.wr_adrr <= '0;
      bus.pixel_out <= '0;
      bus.wr_en <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.wr_en <= state == WR;
      bus.done <= state == WR && last;
      if (state inside {P0, P1, P2, P3}) acc <= acc_nx;
      case (state)
        IDLE:
          if (bus.start) begin
            row <= '0;
            col <= '0;
            base <= '0;
            bus.rd_adrr <= '0;
            bus.busy <= 1'b1;
          end
        P0: bus.rd_adrr <= addr_b;
        P1: bus.rd_adrr <= addr_c;
        P2: bus.rd_adrr <= addr_d;
        WR: begin
          for (int k = 0; k < BPP; k++) bus.pixel_out[8*k +: 8] <= rnd[k][9:2];
          bus.wr_adrr <= base;
          if (last) bus.busy <= 1'b0;
          else begin
            col <= last_c ? '0 : col + CW'(1);
            row <= last_c ? row + RW'(1) : row;
            base <= base + 10'd1;
            bus.rd_adrr <= base + 10'd1;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_box_avg_prefilter.sv
// tb_box_avg_prefilter: directed frames with a clamped-window reference image plus hand-computed spot vectors
module tb_box_avg_prefilter;
  localparam int BPP = 3, H = 30, W = 30, N = H * W, LOG = 8192;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  box_avg_prefilter_if #(.BPP(BPP)) bus();
  box_avg_prefilter #(.BPP(BPP), .HIEGHT(H), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [23:0] mem [0:1023];
  logic [23:0] expi [0:N-1];
  assign bus.pixel_in = mem[bus.rd_adrr];
  int cyc = 0, nwr = 0, n_chk = 0, n_fail = 0;
  logic [9:0] wa [0:LOG-1];
  logic [23:0] wd [0:LOG-1];
  int wt [0:LOG-1];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (bus.wr_en && nwr < LOG) begin
      wa[nwr] <= bus.wr_adrr;
      wd[nwr] <= bus.pixel_out;
      wt[nwr] <= cyc;
      nwr <= nwr + 1;
    end
  typedef struct {
    string name;
    int r;
    int c;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [0:14];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic logic [23:0] ref_px(input int r, input int c);
    int r1, c1, s;
    logic [23:0] a, b, cc, dd, o;
    r1 = (r + 1 > H - 1) ? H - 1 : r + 1;
    c1 = (c + 1 > W - 1) ? W - 1 : c + 1;
    a = mem[10'(r * W + c)];
    b = mem[10'(r * W + c1)];
    cc = mem[10'(r1 * W + c)];
    dd = mem[10'(r1 * W + c1)];
    o = '0;
    for (int k = 0; k < BPP; k++) begin
      s = int'(a[8*k +: 8]) + int'(b[8*k +: 8]) + int'(cc[8*k +: 8]) + int'(dd[8*k +: 8]) + 2;
      o[8*k +: 8] = 8'(s / 4);
    end
    return o;
  endfunction
  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < 1024; i++) mem[i] = v;
  endtask
  task automatic run_frame(input string tag);
    int n0, t0, d, cnt, bo, bt, bd;
    logic got;
    n0 = nwr;
    for (int i = 0; i < N; i++) expi[i] = ref_px(i / W, i % W);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    bus.start = 1'b0;
    @(negedge clk);
    check({tag, "_busy_high"}, 64'(bus.busy), 1);
    got = 1'b0;
    for (int i = 0; i < 5 * N + 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    check({tag, "_done_seen"}, 64'(got), 1);
    if (got) begin
      d = cyc;
      check({tag, "_done_cycle"}, 64'(d - t0), 5 * N);
      check({tag, "_done_with_last_wr"}, {bus.wr_en, bus.wr_adrr}, {1'b1, 10'(N - 1)});
      @(negedge clk);
      check({tag, "_done_single"}, {bus.done, bus.busy, bus.wr_en}, 0);
    end
    #1;
    cnt = nwr - n0;
    check({tag, "_write_count"}, 64'(cnt), N);
    if (cnt > N) cnt = N;
    bo = 0;
    bt = 0;
    bd = 0;
    for (int i = 0; i < cnt; i++) begin
      if (wa[n0 + i] !== 10'(i)) bo++;
      if (wt[n0 + i] != t0 + 5 * (i + 1)) bt++;
      if (wd[n0 + i] !== expi[i]) bd++;
    end
    check({tag, "_addr_order_errs"}, 64'(bo), 0);
    check({tag, "_wr_timing_errs"}, 64'(bt), 0);
    check({tag, "_pixel_errs"}, 64'(bd), 0);
  endtask
  initial begin
    int t0, d, n1;
    logic got;
    vecs[0] = '{"round_0110", 5, 5, 24'h010101};
    vecs[1] = '{"round_1000", 5, 6, 24'h000000};
    vecs[2] = '{"round_0001", 4, 5, 24'h000000};
    vecs[3] = '{"zero_area", 4, 4, 24'h000000};
    vecs[4] = '{"sat_255x4", 10, 10, 24'hFFFFFF};
    vecs[5] = '{"half_255x2", 10, 9, 24'h808080};
    vecs[6] = '{"quarter_255x1", 9, 9, 24'h404040};
    vecs[7] = '{"clamp_col_0_29", 0, 29, 24'h000080};
    vecs[8] = '{"clamp_col_1_29", 1, 29, 24'h000001};
    vecs[9] = '{"edge_0_28", 0, 28, 24'h000040};
    vecs[10] = '{"corner_29_29", 29, 29, 24'h123456};
    vecs[11] = '{"clamp_28_29", 28, 29, 24'h091A2B};
    vecs[12] = '{"clamp_29_28", 29, 28, 24'h091A2B};
    vecs[13] = '{"inner_28_28", 28, 28, 24'h050D16};
    vecs[14] = '{"chan_indep_20_0", 20, 0, 24'h004000};
    bus.start = 1'b0;
    fill(24'h102030);
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.rd_adrr, bus.wr_adrr, bus.pixel_out, bus.wr_en, bus.busy, bus.done}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_without_start", {bus.busy, bus.wr_en, bus.done}, 0);
    run_frame("const");
    fill(24'h000000);
    mem[5*W+6] = 24'h010101;
    mem[6*W+5] = 24'h010101;
    mem[10*W+10] = 24'hFFFFFF;
    mem[10*W+11] = 24'hFFFFFF;
    mem[11*W+10] = 24'hFFFFFF;
    mem[11*W+11] = 24'hFFFFFF;
    mem[0*W+29] = 24'h0000FF;
    mem[1*W+29] = 24'h000001;
    mem[29*W+29] = 24'h123456;
    mem[20*W+0] = 24'h00FF01;
    run_frame("pattern");
    n1 = nwr - N;
    for (int i = 0; i < 15; i++) check(vecs[i].name, wd[n1 + vecs[i].r * W + vecs[i].c], vecs[i].exp);
    fill(24'h102030);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    bus.start = 1'b0;
    while (cyc < t0 + 1000) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("abort_outputs_zero", {bus.rd_adrr, bus.wr_adrr, bus.pixel_out, bus.wr_en, bus.busy, bus.done}, 0);
    n1 = nwr;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    #1 check("abort_no_writes", 64'(nwr - n1), 0);
    check("abort_idle", 64'(bus.busy), 0);
    n1 = nwr;
    run_frame("restart");
    check("restart_first_addr", 64'(wa[n1]), 0);
    n1 = nwr;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 5 * N + 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    check("held_done1_seen", 64'(got), 1);
    d = cyc;
    check("held_done1_cycle", 64'(d - t0), 5 * N);
    check("held_idle_gap", 64'(bus.busy), 0);
    @(negedge clk);
    check("held_rearm_busy", 64'(bus.busy), 1);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = bus.wr_en;
    end
    check("held_frame2_first_wr", {got, bus.wr_adrr}, {1'b1, 10'd0});
    check("held_frame2_first_wr_cycle", 64'(cyc - d), 6);
    got = 1'b0;
    for (int i = 0; i < 5 * N + 20 && !got; i++) begin
      @(negedge clk);
      got = bus.done;
    end
    check("held_done2_seen", 64'(got), 1);
    check("held_done2_cycle", 64'(cyc - d), 5 * N + 1);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #1 check("held_two_frames_writes", 64'(nwr - n1), 2 * N);
    check("held_stop_idle", 64'(bus.busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
